// File: rtl/simple_isa_pkg.sv
// Shared ISA constants for the fetch and decode stages: bubble word, halt opcode,
// instruction class fields and ALU select codes.
package simple_isa_pkg;

    localparam int          ISA_PC_W    = 16;
    localparam logic [15:0] NOP_WORD    = 16'hC0E0;
    localparam logic [3:0]  HLT_WORD_OP = 4'b1111;

    localparam logic [1:0]  CLS_ARITH   = 2'b11;
    localparam logic [1:0]  CLS_IMM_BR  = 2'b10;
    localparam logic [1:0]  CLS_LOAD    = 2'b00;
    localparam logic [1:0]  CLS_STORE   = 2'b01;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SHL = 4'b0101,
        ALU_SHR = 4'b0110,
        ALU_MOV = 4'b0111,
        ALU_NOP = 4'b1110,
        ALU_HLT = 4'b1111
    } alu_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_cmd_history.sv
// Three-deep instruction history feeding the decoder, with hold (no shift)
// and flush (squash the two youngest entries) controls.
module cmd_history
    import simple_isa_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [15:0]     NOP_W    = NOP_WORD,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shift_en,
    input  logic            flush,
    input  logic [15:0]     in_word,
    input  logic [PC_W-1:0] in_pc,
    output logic [15:0]     command,
    output logic [15:0]     before_command,
    output logic [15:0]     two_before_command,
    output logic [PC_W-1:0] cmd_pc
);

    logic [15:0]     cmd_q, before_q, two_before_q;
    logic [15:0]     cmd_d, before_d, two_before_d;
    logic [PC_W-1:0] cmd_pc_q, cmd_pc_d;

    always_comb begin
        cmd_d        = cmd_q;
        before_d     = before_q;
        two_before_d = two_before_q;
        cmd_pc_d     = cmd_pc_q;
        if (flush) begin
            // The older word survives into the oldest slot; both younger ones are squashed.
            two_before_d = before_q;
            before_d     = NOP_W;
            cmd_d        = NOP_W;
            cmd_pc_d     = RESET_PC;
        end else if (shift_en) begin
            two_before_d = before_q;
            before_d     = cmd_q;
            cmd_d        = in_word;
            cmd_pc_d     = in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= NOP_W;
            before_q     <= NOP_W;
            two_before_q <= NOP_W;
            cmd_pc_q     <= RESET_PC;
        end else begin
            cmd_q        <= cmd_d;
            before_q     <= before_d;
            two_before_q <= two_before_d;
            cmd_pc_q     <= cmd_pc_d;
        end
    end

    assign command            = cmd_q;
    assign before_command     = before_q;
    assign two_before_command = two_before_q;
    assign cmd_pc             = cmd_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing against a 1-cycle synchronous ROM,
// one-entry skid buffer for stalls, branch redirect/flush and HLT freeze.
module fetch_unit
    import simple_isa_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [15:0]     NOP_W       = NOP_WORD,
    parameter logic [3:0]      HLT_OP      = HLT_WORD_OP
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     COMMAND,
    output logic [15:0]     BeforeCOMMAND,
    output logic [15:0]     TwoBeforeCOMMAND,
    output logic [PC_W-1:0] cmd_pc,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [15:0]     hold_word_q, hold_word_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;

    logic [15:0]     src_word;
    logic [PC_W-1:0] src_pc;
    logic            src_is_hlt;
    logic            shift_en, flush;

    // Skid buffer has priority: it holds the older word captured during a stall.
    always_comb begin
        src_word = NOP_W;
        src_pc   = RESET_PC;
        if (hold_valid_q) begin
            src_word = hold_word_q;
            src_pc   = hold_pc_q;
        end else if (inflight_valid_q) begin
            src_word = imem_rdata;
            src_pc   = inflight_pc_q;
        end
    end

    assign src_is_hlt = (src_word[15:14] == CLS_ARITH) && (src_word[7:4] == HLT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect)
            state_d = ST_RUN;
        else if (state_q == ST_RUN && !stall && src_is_hlt)
            state_d = ST_HALT;
    end

    always_comb begin
        halted = (state_q == ST_HALT);
    end

    always_comb begin
        pc_d             = pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        hold_valid_d     = hold_valid_q;
        hold_word_d      = hold_word_q;
        hold_pc_d        = hold_pc_q;
        shift_en         = 1'b0;
        flush            = 1'b0;
        if (redirect) begin
            pc_d             = redirect_pc;
            inflight_valid_d = 1'b0;
            hold_valid_d     = 1'b0;
            flush            = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (stall) begin
                if (inflight_valid_q && !hold_valid_q) begin
                    hold_valid_d = 1'b1;
                    hold_word_d  = imem_rdata;
                    hold_pc_d    = inflight_pc_q;
                end
                inflight_valid_d = 1'b0;
            end else begin
                shift_en     = 1'b1;
                hold_valid_d = 1'b0;
                if (src_is_hlt) begin
                    inflight_valid_d = 1'b0;
                end else begin
                    // pc_q already points past any buffered word, so re-request it directly.
                    pc_d             = pc_q + PC_W'(1);
                    inflight_valid_d = 1'b1;
                    inflight_pc_d    = pc_q;
                end
            end
        end else begin
            shift_en = !stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= RESET_PC;
            hold_valid_q     <= 1'b0;
            hold_word_q      <= NOP_W;
            hold_pc_q        <= RESET_PC;
        end else begin
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            hold_valid_q     <= hold_valid_d;
            hold_word_q      <= hold_word_d;
            hold_pc_q        <= hold_pc_d;
        end
    end

    assign imem_addr = pc_q;

    cmd_history #(
        .PC_W     (PC_W),
        .NOP_W    (NOP_W),
        .RESET_PC (RESET_PC)
    ) u_cmd_history (
        .clk                (clk),
        .rst_n              (rst_n),
        .shift_en           (shift_en),
        .flush              (flush),
        .in_word            (src_word),
        .in_pc              (src_pc),
        .command            (COMMAND),
        .before_command     (BeforeCOMMAND),
        .two_before_command (TwoBeforeCOMMAND),
        .cmd_pc             (cmd_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/skid, redirect, HLT,
// stall+redirect collision and asynchronous reset mid-stream.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'hC0E0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND;
    logic [15:0] cmd_pc;
    logic        halted;

    logic [15:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .COMMAND          (COMMAND),
        .BeforeCOMMAND    (BeforeCOMMAND),
        .TwoBeforeCOMMAND (TwoBeforeCOMMAND),
        .cmd_pc           (cmd_pc),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000 + 16'(i);
        imem_rdata  = 16'h0000;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        step();
        step();
        chk("rst_cmd",     COMMAND,          NOP);
        chk("rst_before",  BeforeCOMMAND,    NOP);
        chk("rst_two",     TwoBeforeCOMMAND, NOP);
        chk("rst_cmd_pc",  cmd_pc,           16'h0000);
        chk("rst_halted",  {15'd0, halted},  16'h0000);
        chk("rst_addr",    imem_addr,        16'h0000);
        rst_n = 1'b1;

        // Sequential fetch: first valid word on edge 2
        step(); chk("e1_cmd", COMMAND, NOP);
        step(); chk("e2_cmd", COMMAND, 16'h8000); chk("e2_pc", cmd_pc, 16'h0000);
        step(); chk("e3_cmd", COMMAND, 16'h8001); chk("e3_before", BeforeCOMMAND, 16'h8000);
                chk("e3_two", TwoBeforeCOMMAND, NOP); chk("e3_pc", cmd_pc, 16'h0001);
        step(); chk("e4_pc", cmd_pc, 16'h0002);
        step(); chk("e5_cmd", COMMAND, 16'h8003);

        // Three-cycle stall with COMMAND=8003
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_cmd", COMMAND, 16'h8003);
        end
        stall = 1'b0;
        step(); chk("rel_cmd0", COMMAND, 16'h8004); chk("rel_pc0", cmd_pc, 16'h0004);
        step(); chk("rel_cmd1", COMMAND, 16'h8005); chk("rel_before", BeforeCOMMAND, 16'h8004);
                chk("rel_two", TwoBeforeCOMMAND, 16'h8003);

        // Redirect to 0x40 while COMMAND=8005
        redirect = 1'b1; redirect_pc = 16'h0040;
        step(); chk("rd_cmd", COMMAND, NOP); chk("rd_before", BeforeCOMMAND, NOP);
                chk("rd_two", TwoBeforeCOMMAND, 16'h8004); chk("rd_pc", cmd_pc, 16'h0000);
        redirect = 1'b0;
        step(); chk("rd_bubble", COMMAND, NOP);
        step(); chk("rd_tgt", COMMAND, 16'h8040); chk("rd_tgt_pc", cmd_pc, 16'h0040);
        step(); chk("rd_tgt1", COMMAND, 16'h8041);

        // HLT at mem[5]
        mem[5] = 16'hC0F0;
        redirect = 1'b1; redirect_pc = 16'h0000;
        step(); chk("h_rd_cmd", COMMAND, NOP);
        redirect = 1'b0;
        step();
        step(); chk("h_m0", COMMAND, 16'h8000);
        for (int i = 0; i < 4; i++) step();
        chk("h_m4", COMMAND, 16'h8004); chk("h_pre_halted", {15'd0, halted}, 16'h0000);
        step(); chk("h_cmd", COMMAND, 16'hC0F0); chk("h_halted", {15'd0, halted}, 16'h0001);
                chk("h_addr", imem_addr, 16'h0006);
        step(); chk("h_nop", COMMAND, NOP); chk("h_before", BeforeCOMMAND, 16'hC0F0);
        stall = 1'b1;
        step(); chk("h_stall_before", BeforeCOMMAND, 16'hC0F0);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("h_frz_cmd", COMMAND, NOP);
            chk("h_frz_halt", {15'd0, halted}, 16'h0001);
            chk("h_frz_addr", imem_addr, 16'h0006);
        end
        mem[5] = 16'h8005;
        redirect = 1'b1; redirect_pc = 16'h0000;
        step(); chk("h_exit_halt", {15'd0, halted}, 16'h0000); chk("h_exit_cmd", COMMAND, NOP);
        redirect = 1'b0;
        step();
        step(); chk("h_resume", COMMAND, 16'h8000); chk("h_resume_pc", cmd_pc, 16'h0000);
        step(); chk("h_resume1", COMMAND, 16'h8001);

        // Stall then stall+redirect together: buffered 8002 must be discarded
        stall = 1'b1;
        step(); chk("sr_stall", COMMAND, 16'h8001);
        redirect = 1'b1; redirect_pc = 16'h0040;
        step(); chk("sr_cmd", COMMAND, NOP); chk("sr_before", BeforeCOMMAND, NOP);
                chk("sr_two", TwoBeforeCOMMAND, 16'h8000); chk("sr_pc", cmd_pc, 16'h0000);
        stall = 1'b0; redirect = 1'b0;
        step(); chk("sr_bubble", COMMAND, NOP);
        step(); chk("sr_tgt", COMMAND, 16'h8040); chk("sr_tgt_pc", cmd_pc, 16'h0040);
                chk("sr_tgt_before", BeforeCOMMAND, NOP);
        step(); chk("sr_tgt1", COMMAND, 16'h8041); chk("sr_tgt1_before", BeforeCOMMAND, 16'h8040);

        // Asynchronous reset mid-cycle with the skid buffer full
        stall = 1'b1;
        step(); chk("ar_stall", COMMAND, 16'h8041);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cmd",    COMMAND,          NOP);
        chk("ar_before", BeforeCOMMAND,    NOP);
        chk("ar_two",    TwoBeforeCOMMAND, NOP);
        chk("ar_pc",     cmd_pc,           16'h0000);
        chk("ar_halted", {15'd0, halted},  16'h0000);
        chk("ar_addr",   imem_addr,        16'h0000);
        stall = 1'b0;
        #1 rst_n = 1'b1;
        step(); chk("ar_e1", COMMAND, NOP);
        step(); chk("ar_e2", COMMAND, 16'h8000); chk("ar_e2_pc", cmd_pc, 16'h0000);
        step(); chk("ar_e3", COMMAND, 16'h8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode unit. Maintains the PC and drives a synchronous instruction ROM with 1-cycle read latency.
- Feeds the decoder the current instruction word (COMMAND) plus a two-deep history (BeforeCOMMAND, TwoBeforeCOMMAND).
- Handles pipeline stall, branch redirect with flush, and HLT detection.

Parameters:
- PC_W, 16, PC/instruction-address width.
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_WORD, 16'hC0E0, bubble word: arithmetic class, op field 1110. Decodes to no write, no flag write, no memory access.
- HLT_WORD_OP, 4'b1111, op field [7:4] of the halt instruction. Applies only when bits [15:14] = 2'b11.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  PC_W  ROM read address, driven combinationally from pc_q.
- imem_rdata  in  16  ROM data; equals mem[imem_addr of the previous cycle].
- stall  in  1  decode/hazard stall; hold the history registers.
- redirect  in  1  taken branch/jump resolved downstream (PC_load).
- redirect_pc  in  PC_W  branch target.
- COMMAND  out  16  word presented to the decoder.
- BeforeCOMMAND  out  16  previous COMMAND.
- TwoBeforeCOMMAND  out  16  COMMAND from two shifts earlier.
- cmd_pc  out  PC_W  PC of COMMAND; RESET_PC when COMMAND is a bubble.
- halted  out  1  fetch frozen by HLT.

Behaviour:
- Reset (asynchronous):
  - pc_q=RESET_PC.
  - inflight_valid=0, hold_valid=0.
  - COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND = NOP_WORD.
  - cmd_pc=RESET_PC, halted=0, state=RUN.
- Internal state:
  - inflight_valid, inflight_pc: the word for inflight_pc is on imem_rdata this cycle.
  - hold_valid, hold_word, hold_pc: one-entry skid buffer.
- Source word selection each cycle: hold if hold_valid, else imem_rdata if inflight_valid, else NOP_WORD (bubble).
- States:
  - RUN: normal fetch.
  - HALT: fetch frozen.
- RUN, no stall, no redirect:
  - Shift: TwoBefore<=Before, Before<=COMMAND, COMMAND<=source, cmd_pc<=source pc.
  - Fetch: pc_q<=pc_q+1 (wraps modulo 2^PC_W), inflight_valid<=1, inflight_pc<=pc_q, hold_valid<=0.
  - Latency: the first valid word reaches COMMAND at the 2nd rising edge after reset release. Sustained throughput is 1 word/cycle.
- RUN, stall=1, no redirect:
  - History registers and pc_q hold.
  - If inflight_valid and !hold_valid: hold<=imem_rdata/inflight_pc, hold_valid<=1.
  - inflight_valid<=0.
  - On release, hold is consumed first and mem[pc_q] is re-requested that same cycle. No bubble and no duplicate.
- redirect=1 (any state; overrides stall):
  - pc_q<=redirect_pc, inflight_valid<=0, hold_valid<=0.
  - COMMAND<=NOP_WORD, BeforeCOMMAND<=NOP_WORD (squashes the younger word), TwoBeforeCOMMAND<=BeforeCOMMAND, cmd_pc<=RESET_PC.
  - state<=RUN, halted<=0.
  - Target word reaches COMMAND 2 edges later.
- HLT detection (RUN):
  - Condition: the word shifted into COMMAND has [15:14]=11 and [7:4]=HLT_WORD_OP, with no redirect that cycle.
  - Next state: HALT, halted<=1, inflight_valid<=0, hold_valid<=0, pc_q frozen at its current value.
- HALT:
  - Each non-stalled cycle shifts NOP_WORD in behind HLT.
  - stall is honoured (history holds).
  - Only redirect or reset leaves HALT.
- Simultaneous stall+redirect: redirect wins, as specified above.
- Reset mid-operation: all state is cleared immediately, independent of clk.
- imem_addr is valid every cycle; in HALT it is don't-care but stable.

Decomposition:
- Shared package simple_isa_pkg:
  - NOP_WORD, HLT op code.
  - Class field constants: 2'b11 arithmetic, 2'b10 immediate/branch, 2'b00/01 load/store.
  - ALU select codes shared with the decoder.
- Optional sub-module cmd_history: the 3-deep shift register with hold/flush controls.

Test Plan:
- Reset release, ROM mem[i]=16'h8000+i, no stall: COMMAND=8000 at edge 2, 8001 at edge 3; BeforeCOMMAND=8000 and TwoBeforeCOMMAND=NOP at edge 3; cmd_pc tracks 0,1,2.
- Stall asserted 3 cycles while COMMAND=8003: COMMAND holds 8003 for all 3 cycles; after release COMMAND sequence is 8004, 8005 with no gap or repeat.
- redirect=1, redirect_pc=16'h0040 while COMMAND=8005: next COMMAND=NOP and BeforeCOMMAND=NOP; two edges later COMMAND=mem[0x40], cmd_pc=0x40.
- mem[5]=16'hC0F0 (HLT): COMMAND=C0F0 then halted=1; NOPs follow; pc_q stays fixed for 10 cycles; redirect to 0 clears halted and resumes from mem[0].
- stall and redirect asserted in the same cycle: redirect behaviour exactly as in scenario 3; hold buffer discarded, so the stalled word never reappears.
- rst_n pulsed low mid-stream with hold_valid=1: outputs go to NOP/RESET_PC/halted=0 immediately; fetch restarts from mem[0].
